// File: rtl/text_cursor_plotter.sv
// Character-stream to VGA plot engine: keeps a text cursor on a COLS x ROWS grid and draws glyphs
// fetched from an external 1-cycle ROM. Define TEXT_PLOT_TRANSPARENT_BG_EN to plot only set glyph bits.
module text_cursor_plotter #(
    parameter int CHAR_W  = 8,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 8,
    parameter int COLS    = 40,
    parameter int ROWS    = 30,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [CHAR_W-1:0]                  char_in,
    input  logic                               char_valid,
    output logic                               char_ready,
    input  logic [COLOR_W-1:0]                 fg_colour,
    input  logic [COLOR_W-1:0]                 bg_colour,
    output logic [CHAR_W+$clog2(GLYPH_H)-1:0]  glyph_addr,
    input  logic [GLYPH_W-1:0]                 glyph_row,
    output logic [X_W-1:0]                     x,
    output logic [Y_W-1:0]                     y,
    output logic [COLOR_W-1:0]                 colour,
    output logic                               plot,
    output logic                               busy
);

    // Counter widths assume GLYPH_W, GLYPH_H, COLS and ROWS are all at least 2.
    localparam int RW   = $clog2(GLYPH_H);
    localparam int PW   = $clog2(GLYPH_W);
    localparam int CW   = $clog2(COLS);
    localparam int ROWW = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DRAW,
        S_ADVANCE,
        S_NEWLINE
    } state_t;

    state_t               state_q, state_d;
    logic [CHAR_W-1:0]    char_q, char_d;
    logic [COLOR_W-1:0]   fg_q, fg_d;
    logic [COLOR_W-1:0]   bg_q, bg_d;
    logic [GLYPH_W-1:0]   glyph_q, glyph_d;
    logic [RW-1:0]        r_q, r_d;
    logic [PW-1:0]        px_q, px_d;
    logic [CW-1:0]        col_q, col_d;
    logic [ROWW-1:0]      row_q, row_d;

    logic                 pix_on;
    logic [ROWW-1:0]      row_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            char_q  <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            glyph_q <= '0;
            r_q     <= '0;
            px_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            glyph_q <= glyph_d;
            r_q     <= r_d;
            px_q    <= px_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Row advance shared by end-of-line wrap and newline; wraps to the top, no scrolling.
    assign row_inc = (row_q == ROWW'(ROWS - 1)) ? '0 : row_q + ROWW'(1);

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        glyph_d = glyph_q;
        r_d     = r_q;
        px_d    = px_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (char_valid && char_ready) begin
                    char_d = char_in;
                    fg_d   = fg_colour;
                    bg_d   = bg_colour;
                    if (char_in == CHAR_W'(8'h0A)) begin
                        state_d = S_NEWLINE;
                    end else if (char_in >= CHAR_W'(8'h20)) begin
                        r_d     = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                glyph_d = glyph_row;
                px_d    = '0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (px_q == PW'(GLYPH_W - 1)) begin
                    if (r_q == RW'(GLYPH_H - 1)) begin
                        state_d = S_ADVANCE;
                    end else begin
                        r_d     = r_q + RW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    px_d = px_q + PW'(1);
                end
            end
            S_ADVANCE: begin
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_inc;
                end else begin
                    col_d = col_q + CW'(1);
                end
                state_d = S_IDLE;
            end
            S_NEWLINE: begin
                col_d   = '0;
                row_d   = row_inc;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MSB of the glyph row is the leftmost pixel.
    assign pix_on = glyph_q[PW'(GLYPH_W - 1) - px_q];

    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        if (state_q == S_DRAW) begin
            x = X_W'(col_q) * X_W'(GLYPH_W) + X_W'(px_q);
            y = Y_W'(row_q) * Y_W'(GLYPH_H) + Y_W'(r_q);
`ifdef TEXT_PLOT_TRANSPARENT_BG_EN
            plot   = pix_on;
            colour = fg_q;
`else
            plot   = 1'b1;
            colour = pix_on ? fg_q : bg_q;
`endif
        end
    end

    assign glyph_addr = {char_q, r_q};
    assign char_ready = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_text_cursor_plotter.sv
// Scoreboard bench for text_cursor_plotter: directed characters push expected pixels, a negedge monitor checks plots.
module tb_text_cursor_plotter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [2:0]  fg_colour = 3'b000;
    logic [2:0]  bg_colour = 3'b000;
    logic [10:0] glyph_addr;
    logic [7:0]  glyph_row;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;

    text_cursor_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fg_colour  (fg_colour),
        .bg_colour  (bg_colour),
        .glyph_addr (glyph_addr),
        .glyph_row  (glyph_row),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rom_mode = 1'b0;
    int   cur_col = 0;
    int   cur_row = 0;

    // mode 0: every row 8'h81; mode 1: row r has only bit r set
    function automatic logic [7:0] rom_f(input logic [2:0] r);
        rom_f = rom_mode ? (8'h01 << r) : 8'h81;
    endfunction

    always @(posedge clock) glyph_row <= rom_f(glyph_addr[2:0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        pix_t a, e;
        if (!reset && plot) begin
            a.x = x; a.y = y; a.c = colour;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot", x, y, colour);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             a.x, a.y, a.c, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic newline_model();
        cur_col = 0;
        cur_row = (cur_row == 29) ? 0 : cur_row + 1;
    endtask

    task automatic push_char(input logic [7:0] c, input logic [2:0] f, input logic [2:0] b,
                             output int eb, output int ep);
        pix_t       e;
        logic [7:0] g;
        logic       on;
        ep = 0;
        if (c == 8'h0A) begin
            eb = 1;
            newline_model();
        end else if (c < 8'h20) begin
            eb = 0;
        end else begin
            eb = 81;
            for (int r = 0; r < 8; r++) begin
                g = rom_f(3'(r));
                for (int px = 0; px < 8; px++) begin
                    on  = g[7 - px];
                    e.x = 9'(cur_col * 8 + px);
                    e.y = 8'(cur_row * 8 + r);
`ifdef TEXT_PLOT_TRANSPARENT_BG_EN
                    e.c = f;
                    if (on) begin
                        sb.push_back(e);
                        ep++;
                    end
`else
                    e.c = on ? f : b;
                    sb.push_back(e);
                    ep++;
`endif
                end
            end
            if (cur_col == 39) newline_model();
            else cur_col++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!char_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_char(input logic [7:0] c, input logic [2:0] f, input logic [2:0] b);
        int eb, ep, nb, pl;
        wait_ready();
        push_char(c, f, b, eb, ep);
        char_in = c; fg_colour = f; bg_colour = b; char_valid = 1'b1;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        // garbage while busy must not disturb the character in progress
        char_in = 8'h5A; fg_colour = ~f; bg_colour = ~b;
        nb = 0; pl = 0;
        forever begin
            @(negedge clock);
            if (!busy || nb > 1000) break;
            nb++;
            if (plot) pl++;
        end
        chk("busy_cycles", nb, eb);
        chk("plot_pulses", pl, ep);
        chk("ready_after", char_ready, 1);
    endtask

    initial begin
        int eb, ep;
        repeat (3) @(negedge clock);
        chk("rst_ready", char_ready, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_addr", glyph_addr, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("ready_release", char_ready, 1);

        send_char(8'h41, 3'b010, 3'b111);
        chk("cursor_after_A", cur_col, 1);

        for (int i = 0; i < 39; i++) send_char(8'h42 + 8'(i % 20), 3'(i), ~3'(i));
        send_char(8'h43, 3'b001, 3'b100);          // lands at x=0, y=8
        for (int i = 0; i < 4; i++) send_char(8'h30, 3'b011, 3'b000);
        for (int i = 0; i < 28; i++) send_char(8'h0A, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) send_char(8'h31, 3'b101, 3'b010);
        chk("cursor_5_29", cur_col * 100 + cur_row, 529);
        send_char(8'h0A, 3'b000, 3'b000);          // row 29 wraps to 0
        send_char(8'h44, 3'b110, 3'b001);          // draws at (0,0)
        send_char(8'h09, 3'b111, 3'b111);          // silently consumed
        send_char(8'h45, 3'b011, 3'b100);          // draws at x=8
        rom_mode = 1'b1;
        send_char(8'h46, 3'b101, 3'b010);          // diagonal glyph at x=16

        // abort during DRAW r=4 px=3 of the character at column 3
        wait_ready();
        push_char(8'h60, 3'b110, 3'b001, eb, ep);
        char_in = 8'h60; fg_colour = 3'b110; bg_colour = 3'b001; char_valid = 1'b1;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        repeat (46) @(negedge clock);
        chk("pre_rst_plot", plot, 1);
        chk("pre_rst_x", x, 27);
        chk("pre_rst_y", y, 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", char_ready, 0);
        sb.delete();
        cur_col = 0;
        cur_row = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", char_ready, 1);
        send_char(8'h47, 3'b100, 3'b011);          // back at (0,0)

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_cursor_plotter.md
Name: text_cursor_plotter

Overview:
- Parametrised successor to the fixed char-stream-to-VGA path.
- Accepts a character stream via a valid/ready handshake and keeps a text cursor on a COLS x ROWS character grid.
- Fetches glyph rows from an external 1-cycle-latency glyph ROM and emits one pixel per cycle on the vga_adapter plot interface (x, y, colour, plot).
- Sits between the stream reader and the VGA adapter; char_ready replaces the old pause signal.

Parameters:
CHAR_W, 8, character code width
GLYPH_W, 8, glyph width in pixels (also glyph_row width)
GLYPH_H, 8, glyph height in pixels
COLS, 40, characters per text row
ROWS, 30, text rows on screen
X_W, 9, VGA x coordinate width
Y_W, 8, VGA y coordinate width
COLOR_W, 3, colour width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
char_in  in  CHAR_W  character code
char_valid  in  1  char_in valid
char_ready  out  1  block can accept a character; the source pauses while low
fg_colour  in  COLOR_W  foreground colour, sampled at acceptance
bg_colour  in  COLOR_W  background colour, sampled at acceptance
glyph_addr  out  CHAR_W+clog2(GLYPH_H)  {char, glyph row} to glyph ROM
glyph_row  in  GLYPH_W  ROM data, valid 1 cycle after glyph_addr; MSB = leftmost pixel
x  out  X_W  pixel x
y  out  Y_W  pixel y
colour  out  COLOR_W  pixel colour
plot  out  1  write strobe to the VGA adapter
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: char_ready=0 while reset is asserted, 1 in the first IDLE cycle after release. plot=0, x=0, y=0, colour=0, glyph_addr=0, busy=0. Cursor (col,row)=(0,0). FSM=IDLE.
- Reset mid-character aborts immediately. No further plot pulses. Cursor returns to (0,0).
- States: IDLE, FETCH, LATCH, DRAW, ADVANCE, NEWLINE.
- IDLE: char_ready=1. Handshake = char_valid && char_ready at a rising edge. On handshake, latch char, fg_colour and bg_colour.
  - char==0x0A goes to NEWLINE.
  - char<0x20 (other) is consumed silently and stays in IDLE.
  - Otherwise go to FETCH with glyph row r=0.
- FETCH (1 cycle): glyph_addr={char,r}. Go to LATCH.
- LATCH (1 cycle): register glyph_row. Go to DRAW with px=0.
- DRAW (GLYPH_W cycles): plot=1 every cycle.
  - x = col*GLYPH_W+px; y = row*GLYPH_H+r. Arithmetic is truncated to X_W/Y_W.
  - colour = glyph bit [GLYPH_W-1-px] ? fg : bg.
  - At px=GLYPH_W-1: if r<GLYPH_H-1, r++ and go to FETCH; else go to ADVANCE.
- ADVANCE (1 cycle, plot=0):
  - col++.
  - If col==COLS-1: col=0, row++.
  - If row==ROWS-1 at that wrap: row=0 (wrap to top, no scroll).
- NEWLINE (1 cycle, plot=0): col=0, row++ with the same wrap to 0. Go to IDLE.
- char_ready=0 in every non-IDLE state. busy = ~IDLE.
- Printable char: GLYPH_H*(GLYPH_W+2)+1 non-IDLE cycles. This is 81 at defaults, with exactly GLYPH_W*GLYPH_H plot pulses (64). Newline: 1 non-IDLE cycle.
- Back-to-back: char_valid held high gives acceptance on the first IDLE cycle. No idle gap beyond that single IDLE cycle.
- char_in/colours changing while busy have no effect on the character in progress.

Optional Feature:
TEXT_PLOT_TRANSPARENT_BG_EN
- Defined: in DRAW, plot=1 only for set glyph bits. Clear bits keep plot=0 but still take one cycle. Timing is identical and bg_colour is ignored.
- Undefined: every glyph pixel is plotted, using bg_colour for clear bits.

Test Plan:
- Reset release, then char 0x41 with fg=3'b010, bg=3'b111, ROM row r=8'h81 for all rows:
  - 64 plot pulses: x=0..7, y=0..7, colour 010 at x=0 and x=7, 111 elsewhere.
  - char_ready returns high 81 cycles after acceptance.
  - Cursor ends at (1,0).
- 40 printable chars: the 40th draws at x=312..319, y=0..7. The next char draws at x=0, y=8.
- Cursor at (5,29), send 0x0A: 1 busy cycle, no plot. Next char draws at x=0, y=0 (row wrap).
- Send 0x09 (non-printable): accepted in 1 cycle, busy stays 0, no plot, cursor unchanged.
- Assert reset at DRAW px=3 of row 4: plot=0 in the same cycle (async). After release, char_ready=1 and the next char draws at (0,0).
- With TEXT_PLOT_TRANSPARENT_BG_EN and ROM=8'h81: 16 plot pulses per char, still 81 busy cycles.
